// File: rtl/comptador_universal.sv
// Universal counter: width-parametrised up/down count, clamped load, programmable terminal value, wrap or saturate.
// Latency: every output is registered, so an input sampled at edge N is visible after edge N.
// Backpressure: none. en gates stepping, and the counter holds its value while en and load are both low.
module comptador_universal #(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] max,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [WIDTH-1:0] nxt_out;
    logic             boundary;
    logic             nxt_ovf;

    always_comb begin
        nxt_out  = out;
        boundary = 1'b0;
        if (load) begin
            nxt_out = (din > max) ? max : din;
        end else if (en) begin
            // A count left above a freshly lowered max snaps back into range.
            // This is not a boundary event.
            if (out > max) begin
                nxt_out = max;
            end else if (up) begin
                if (out == max) begin
                    boundary = 1'b1;
                    nxt_out  = (SATURATE != 0) ? max : ZERO;
                end else begin
                    nxt_out = out + ONE;
                end
            end else begin
                if (out == ZERO) begin
                    boundary = 1'b1;
                    nxt_out  = (SATURATE != 0) ? ZERO : max;
                end else begin
                    nxt_out = out - ONE;
                end
            end
        end
    end

    // A boundary event in the same cycle as clr_ovf leaves ovf set.
    assign nxt_ovf = boundary ? 1'b1 : (clr_ovf ? 1'b0 : ovf);

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= ZERO;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            out <= nxt_out;
            tc  <= boundary;
            ovf <= nxt_ovf;
        end
    end

endmodule

// File: doc/comptador_universal.md
# comptador_universal

Parametrised synchronous counter, successor to the fixed 8-bit enable counter. Adds configurable width, up/down direction, synchronous parallel load, a runtime-programmable terminal value, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag. Intended as the general counting primitive for timers, address generators and event counters in later labs.

## Interface

Parameters:
- WIDTH, 8, counter width in bits (≥2).
- SATURATE, 0, boundary mode: 0 = wrap, 1 = saturate (hold at limit).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  count enable; one step per enabled cycle.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous parallel load of din.
- din  in  WIDTH  load value.
- max  in  WIDTH  terminal value; legal range is 0..max inclusive.
- clr_ovf  in  1  clears the sticky ovf flag.
- out  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered, one cycle wide.
- ovf  out  1  sticky boundary flag, registered.

## Operation

- Priority per cycle: rst > load > en. up is ignored unless en=1 and load=0.
- Reset (rst=1): out=0, tc=0, ovf=0, regardless of other inputs.
- Load (load=1): out <= din if din ≤ max, else out <= max. No tc, no ovf change except clr_ovf.
- Enabled step, up=1:
  - out < max: out <= out+1.
  - out == max: boundary event. Wrap mode: out <= 0. Saturate mode: out holds max.
- Enabled step, up=0:
  - 0 < out ≤ max: out <= out−1.
  - out == 0: boundary event. Wrap mode: out <= max. Saturate mode: out holds 0.
- out > max (max lowered at runtime): the next enabled step in either direction sets out <= max. This is not a boundary event.
- en=0, load=0: out holds, tc=0.
- Boundary event: tc=1 in the following cycle only, and ovf set to 1.
- ovf: cleared by clr_ovf=1. A boundary event in the same cycle as clr_ovf wins, so ovf stays 1.
- max = 0: every enabled step is a boundary event. out stays 0 in both modes, and tc pulses on each enabled cycle.
- Arithmetic is unsigned, modulo 2^WIDTH internally. No intermediate wider than WIDTH+1 bits is needed.

## Timing

- All outputs are registered. There is no combinational path from any input to any output.
- Latency: the effect of any input sampled at edge N is visible after edge N, i.e. during cycle N+1.
- tc asserts in the same cycle that out shows the wrapped or held value.
- Back-to-back boundary events (e.g. saturate mode, en held high at max) give tc high continuously, one pulse per cycle.
- rst asserted mid-count takes effect at the next edge. It overrides a simultaneous load, en or boundary event, and tc and ovf are 0 in the following cycle.
- Inputs must be stable around the clk edge. No CDC is handled here.

## Test plan

- Reset and hold: rst=1 for 2 cycles with en=1, load=1, din=8'h55 -> out=0, tc=0, ovf=0. Release rst with en=0 -> out stays 0.
- Wrap up: WIDTH=8, SATURATE=0, max=8'd9, up=1, en=1 for 12 cycles from 0 -> out 1,2…9,0,1,2. tc high exactly in the cycle out=0. ovf=1 afterwards.
- Wrap down and clear: max=8'd5, up=0, en=1 from out=0 -> out 5,4,3 with tc in the cycle out=5. Then clr_ovf=1 for 1 cycle -> ovf=0.
- Saturate: SATURATE=1, max=8'hFF, load din=8'hFD, then en=1, up=1 for 5 cycles -> out FE, FF, FF, FF, FF. tc high during the three held FF cycles. ovf=1.
- Load priority and clamp: en=1, up=1, load=1, din=8'd20, max=8'd15 -> out=15, no tc. Next cycle load=0, en=1 -> out=0 and tc=1.
- Runtime max reduction and simultaneity: out=8'd12, max changed to 8'd7, en=1, up=0 -> out=7, no tc. Boundary event with clr_ovf=1 in the same cycle -> ovf remains 1. rst during that event -> out=0, tc=0, ovf=0.
